// File: rtl/instr_dispatcher.sv
// -----------------------------------------------------------------------------
// instr_dispatcher
//
// In-order, single-issue dispatcher between the instruction FIFO and the three
// TPU execution controllers (weight flow, matrix multiply, activation).
// A one-entry hold register keeps the current instruction until its target
// controller and that controller's upstream dependency are free. The
// instruction then retires with a one-cycle issue pulse and a registered copy
// of the opcode and payload. SYNC waits for every controller to drain.
// HALT parks the block in HALTED until `resume` is seen.
//
// Handshake: an instruction transfers on a clock edge where
// instr_valid && instr_ready. instr_ready does not depend on instr_valid.
// A retire and an accept may share one edge, so one instruction per cycle
// can be sustained.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   enable                   global advance; low freezes state, pulses read 0
//   instr_valid/instr_ready  instruction FIFO handshake
//   instr_op, instr_payload  opcode and operands of the offered instruction
//   *_busy, *_resource_busy  controller status inputs
//   resume                   leaves HALTED
//   *_instr_enable           one-cycle issue pulses, one per controller
//   out_op, out_payload      last issued unit instruction, held until next
//   sync_done, illegal_instr one-cycle pulses
//   halted                   FSM state (high in HALTED)
//   retired_count            retired instructions, wraps at 16 bits
// -----------------------------------------------------------------------------
module instr_dispatcher #(
  parameter int PAYLOAD_WIDTH = 72
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [7:0]               instr_op,
  input  logic [PAYLOAD_WIDTH-1:0] instr_payload,
  input  logic                     weight_busy,
  input  logic                     weight_resource_busy,
  input  logic                     matmul_busy,
  input  logic                     matmul_resource_busy,
  input  logic                     act_busy,
  input  logic                     act_resource_busy,
  input  logic                     resume,
  output logic                     weight_instr_enable,
  output logic                     matmul_instr_enable,
  output logic                     act_instr_enable,
  output logic [7:0]               out_op,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic                     sync_done,
  output logic                     illegal_instr,
  output logic                     halted,
  output logic [15:0]              retired_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_SYNC,
    C_HALT,
    C_WEIGHT,
    C_MATMUL,
    C_ACT,
    C_ILLEGAL
  } op_class_t;

  state_t                   state_q, state_d;
  logic                     hold_valid;
  logic [7:0]               hold_op;
  logic [PAYLOAD_WIDTH-1:0] hold_payload;
  op_class_t                hold_class;

  // Guard flags cover the cycle between an issue and the unit raising busy.
  logic g_w, g_m, g_a;
  // Pulse registers; the outputs are these gated by enable.
  logic w_q, m_q, a_q, sync_q, ill_q;

  logic can_issue, retire, accept;

  // Nothing sits downstream of the activation controller, so its busy flag
  // never gates an issue.
  logic unused;
  assign unused = act_busy;

  // Opcode decode; the unit ranges are disjoint.
  always_comb begin
    hold_class = C_ILLEGAL;
    if (hold_op[7])                     hold_class = C_ACT;
    else if (hold_op[7:5] == 3'b001)    hold_class = C_MATMUL;
    else if (hold_op[7:3] == 5'b00001)  hold_class = C_WEIGHT;
    else if (hold_op == 8'h00)          hold_class = C_NOP;
    else if (hold_op == 8'h01)          hold_class = C_SYNC;
    else if (hold_op == 8'h02)          hold_class = C_HALT;
  end

  // Each unit waits on its own resource and on its upstream producer.
  always_comb begin
    can_issue = 1'b1;
    case (hold_class)
      C_WEIGHT: can_issue = !weight_resource_busy && !g_w;
      C_MATMUL: can_issue = !matmul_resource_busy && !g_m && !weight_busy && !g_w;
      C_ACT:    can_issue = !act_resource_busy && !g_a && !matmul_busy && !g_m;
      C_SYNC:   can_issue = !weight_resource_busy && !matmul_resource_busy &&
                            !act_resource_busy && !g_w && !g_m && !g_a;
      default:  can_issue = 1'b1;
    endcase
  end

  assign retire      = enable && hold_valid && can_issue;
  assign instr_ready = enable && (state_q == RUN) && (!hold_valid || can_issue) &&
                       !(hold_valid && hold_class == C_HALT);
  assign accept      = instr_valid && instr_ready;

  // Next state. resume is only looked at in HALTED, so a resume arriving on
  // the same edge as the HALT retire is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (retire && hold_class == C_HALT) state_d = HALTED;
      HALTED:  if (enable && resume)               state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      hold_valid    <= 1'b0;
      hold_op       <= '0;
      hold_payload  <= '0;
      g_w           <= 1'b0;
      g_m           <= 1'b0;
      g_a           <= 1'b0;
      w_q           <= 1'b0;
      m_q           <= 1'b0;
      a_q           <= 1'b0;
      sync_q        <= 1'b0;
      ill_q         <= 1'b0;
      out_op        <= '0;
      out_payload   <= '0;
      retired_count <= '0;
    end else if (enable) begin
      state_q <= state_d;
      if (accept) begin
        hold_valid   <= 1'b1;
        hold_op      <= instr_op;
        hold_payload <= instr_payload;
      end else if (retire) begin
        hold_valid <= 1'b0;
      end
      g_w    <= retire && hold_class == C_WEIGHT;
      g_m    <= retire && hold_class == C_MATMUL;
      g_a    <= retire && hold_class == C_ACT;
      w_q    <= retire && hold_class == C_WEIGHT;
      m_q    <= retire && hold_class == C_MATMUL;
      a_q    <= retire && hold_class == C_ACT;
      sync_q <= retire && hold_class == C_SYNC;
      ill_q  <= retire && hold_class == C_ILLEGAL;
      if (retire && (hold_class == C_WEIGHT || hold_class == C_MATMUL ||
                     hold_class == C_ACT)) begin
        out_op      <= hold_op;
        out_payload <= hold_payload;
      end
      if (retire) retired_count <= retired_count + 16'd1;
    end else begin
      // A pulse must not survive a frozen cycle and reappear afterwards.
      w_q    <= 1'b0;
      m_q    <= 1'b0;
      a_q    <= 1'b0;
      sync_q <= 1'b0;
      ill_q  <= 1'b0;
    end
  end

  assign weight_instr_enable = w_q && enable;
  assign matmul_instr_enable = m_q && enable;
  assign act_instr_enable    = a_q && enable;
  assign sync_done           = sync_q && enable;
  assign illegal_instr       = ill_q && enable;
  assign halted              = (state_q == HALTED);

endmodule
